// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBus definitions: request/response structs, burst/length/size types,
// default responder constants and the byte-lane merge helper.
package cbus_sram_responder_pkg;

  localparam int CBUS_DEFAULT_LATENCY     = 2;
  localparam int CBUS_DEFAULT_DEPTH_WORDS = 1024;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 64;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

  // Encoded burst length: beats = len + 1.
  typedef logic [2:0] mlen_t;
  localparam mlen_t MLEN1 = 3'd0;
  localparam mlen_t MLEN2 = 3'd1;
  localparam mlen_t MLEN3 = 3'd2;
  localparam mlen_t MLEN4 = 3'd3;
  localparam mlen_t MLEN5 = 3'd4;
  localparam mlen_t MLEN6 = 3'd5;
  localparam mlen_t MLEN7 = 3'd6;
  localparam mlen_t MLEN8 = 3'd7;

  typedef enum logic [1:0] {
    MSIZE_1B = 2'd0,
    MSIZE_2B = 2'd1,
    MSIZE_4B = 2'd2,
    MSIZE_8B = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [CBUS_ADDR_W-1:0] addr;
    mlen_t                  len;
    msize_t                 size;
    axi_burst_t             burst;
    logic [CBUS_DATA_W-1:0] data;
    logic [CBUS_STRB_W-1:0] strobe;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_LATENCY_WAIT = 2'd1,
    ST_BEAT         = 2'd2,
    ST_RELEASE      = 2'd3
  } cbus_sram_state_t;

  function automatic logic [CBUS_DATA_W-1:0] cbus_merge_bytes(
    input logic [CBUS_DATA_W-1:0] old_word,
    input logic [CBUS_DATA_W-1:0] new_word,
    input logic [CBUS_STRB_W-1:0] strb
  );
    logic [CBUS_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < CBUS_STRB_W; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cbus_sram_array.sv
// Byte-strobed 64-bit word storage: one asynchronous read port, one
// synchronous write port. Contents are never reset.
module cbus_sram_array
  import cbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = CBUS_DEFAULT_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx_i,
  output logic [CBUS_DATA_W-1:0]         rd_data_o,
  input  logic                           wr_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx_i,
  input  logic [CBUS_DATA_W-1:0]         wr_data_i,
  input  logic [CBUS_STRB_W-1:0]         wr_strb_i
);

  logic [CBUS_DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= cbus_merge_bytes(mem_q[wr_idx_i], wr_data_i, wr_strb_i);
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus SRAM responder: accepts one burst request at a time, waits a fixed
// latency, then streams len+1 back-to-back beats against cbus_sram_array.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = CBUS_DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = CBUS_DEFAULT_LATENCY
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  request_from_bus,
  output cbus_resp_t response_to_bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  cbus_sram_state_t       state_q;
  logic [3:0]             cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_d;
  mlen_t                  len_q;
  mlen_t                  beat_q;
  axi_burst_t             burst_q;
  logic                   is_write_q;
  logic                   oor_q;
  cbus_resp_t             resp_q;

  logic [IDX_W-1:0]       req_idx;
  logic                   req_oor;
  logic                   wr_en;
  logic [CBUS_DATA_W-1:0] rd_word;
  logic                   unused_req_bits;

  // Byte offset bits and transfer size play no part in word addressing.
  assign req_idx         = request_from_bus.addr[IDX_W+2:3];
  assign req_oor         = |request_from_bus.addr[CBUS_ADDR_W-1:IDX_W+3];
  assign unused_req_bits = ^{request_from_bus.addr[2:0], request_from_bus.size};

  always_comb begin
    idx_d = idx_q;
    if (burst_q != AXI_BURST_FIXED) idx_d = idx_q + 1'b1;
  end

  assign wr_en = (state_q == ST_BEAT) && is_write_q && !oor_q;

  cbus_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_word),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (request_from_bus.data),
    .wr_strb_i (request_from_bus.strobe)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      burst_q    <= AXI_BURST_FIXED;
      is_write_q <= 1'b0;
      oor_q      <= 1'b0;
      resp_q     <= '0;
    end else begin
      resp_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (request_from_bus.valid) begin
            idx_q      <= req_idx;
            oor_q      <= req_oor;
            len_q      <= request_from_bus.len;
            burst_q    <= request_from_bus.burst;
            is_write_q <= request_from_bus.is_write;
            cnt_q      <= LAT_LOAD;
            beat_q     <= '0;
            state_q    <= (LATENCY == 1) ? ST_BEAT : ST_LATENCY_WAIT;
          end
        end
        ST_LATENCY_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_BEAT;
        end
        ST_BEAT: begin
          // Each edge spent here issues one beat; write data is sampled live.
          resp_q.ready <= 1'b1;
          resp_q.last  <= (beat_q == len_q);
          resp_q.data  <= (is_write_q || oor_q) ? '0 : rd_word;
          idx_q        <= idx_d;
          if (beat_q == len_q) begin
            state_q <= ST_RELEASE;
          end else begin
            beat_q <= beat_q + 3'd1;
          end
        end
        ST_RELEASE: begin
          if (!request_from_bus.valid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign response_to_bus = resp_q;

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder with hand-computed expectations.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic       clk;
  logic       rst_n;
  cbus_req_t  req;
  cbus_resp_t resp;

  int n_chk;
  int n_err;
  logic [63:0] wbuf [8];
  logic [63:0] rbuf [8];

  cbus_sram_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .request_from_bus (req),
    .response_to_bus  (resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction with cycle-exact handshake checks. When hold is set,
  // valid stays high through the whole burst and the caller drops it.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input int len,
                         input axi_burst_t burst, input logic [7:0] strb, input logic hold);
    req.valid    = 1'b1;
    req.is_write = wr;
    req.addr     = addr;
    req.len      = mlen_t'(len);
    req.burst    = burst;
    req.size     = MSIZE_8B;
    req.strobe   = strb;
    req.data     = wr ? wbuf[0] : 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    if (!hold) req.valid = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      check_eq("lat_ready", 64'(resp.ready), 64'd0);
      tick();
    end
    for (int b = 0; b <= len; b++) begin
      check_eq("beat_ready", 64'(resp.ready), 64'd1);
      check_eq("beat_last", 64'(resp.last), 64'(b == len));
      if (wr) begin
        check_eq("wr_data_zero", resp.data, 64'd0);
        if (b < 7) req.data = wbuf[b+1];
      end else begin
        rbuf[b] = resp.data;
      end
      tick();
    end
    check_eq("post_ready", 64'(resp.ready), 64'd0);
    check_eq("post_data", resp.data, 64'd0);
  endtask

  task automatic read1(input logic [31:0] addr, input logic [63:0] exp, input string tag);
    run_txn(1'b0, addr, 0, AXI_BURST_INCR, 8'h00, 1'b0);
    check_eq(tag, rbuf[0], exp);
  endtask

  task automatic write1(input logic [31:0] addr, input logic [63:0] d, input logic [7:0] strb);
    wbuf[0] = d;
    run_txn(1'b1, addr, 0, AXI_BURST_INCR, strb, 1'b0);
  endtask

  logic [31:0] top_addr [4];
  logic [63:0] top_val  [4];
  logic [63:0] pat_p    [4];
  logic [63:0] pat_q    [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    top_addr = '{32'h0000_1FF8, 32'h0000_0000, 32'h0000_0008, 32'h0000_0010};
    top_val  = '{64'hA0A0_0000_0000_03FF, 64'hA1A1_0000_0000_0000,
                 64'hA2A2_0000_0000_0001, 64'hA3A3_0000_0000_0002};
    pat_p    = '{64'h5050_5050_0000_0000, 64'h5151_5151_1111_1111,
                 64'h5252_5252_2222_2222, 64'h5353_5353_3333_3333};
    pat_q    = '{64'hC0C0_0000_FFFF_0000, 64'hC1C1_0000_FFFF_0001,
                 64'hC2C2_0000_FFFF_0002, 64'hC3C3_0000_FFFF_0003};
    repeat (3) tick();
    check_eq("rst_resp", 64'(resp.ready) | 64'(resp.last) | resp.data, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single-beat write then read of 0x40
    write1(32'h40, 64'h1122_3344_5566_7788, 8'hFF);
    read1(32'h40, 64'h1122_3344_5566_7788, "rd_0x40");

    // Byte-strobed partial write, then low address bits ignored
    write1(32'h40, 64'h00CD_0000_0000_0000, 8'h40);
    read1(32'h40, 64'h11CD_3344_5566_7788, "rd_strobe");
    read1(32'h47, 64'h11CD_3344_5566_7788, "rd_lowbits");

    // INCR wrap across the top word and FIXED repeat
    for (int i = 0; i < 4; i++) write1(top_addr[i], top_val[i], 8'hFF);
    run_txn(1'b0, 32'h1FF8, 3, AXI_BURST_INCR, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) check_eq("incr_wrap", rbuf[i], top_val[i]);
    run_txn(1'b0, 32'h1FFD, 3, AXI_BURST_FIXED, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) check_eq("fixed_rpt", rbuf[i], top_val[0]);

    // Multi-beat INCR write with live per-beat data
    for (int i = 0; i < 4; i++) wbuf[i] = pat_p[i];
    run_txn(1'b1, 32'h100, 3, AXI_BURST_INCR, 8'hFF, 1'b0);
    run_txn(1'b0, 32'h100, 3, AXI_BURST_INCR, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) check_eq("incr_wr", rbuf[i], pat_p[i]);

    // Valid held one cycle past last: single release, then next request
    run_txn(1'b0, 32'h40, 0, AXI_BURST_INCR, 8'h00, 1'b1);
    check_eq("hold_rd", rbuf[0], 64'h11CD_3344_5566_7788);
    req.valid = 1'b0;
    tick();
    check_eq("hold_norepeat", 64'(resp.ready), 64'd0);
    read1(32'h1FF8, top_val[0], "after_hold");

    // Out-of-range read returns zero; out-of-range write dropped
    write1(32'h2040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    read1(32'h0001_0040, 64'd0, "oor_rd");
    read1(32'h40, 64'h11CD_3344_5566_7788, "oor_wr_drop");

    // Reset during latency wait: nothing committed
    for (int i = 0; i < 4; i++) wbuf[i] = pat_q[i];
    req = '0;
    req.valid = 1'b1; req.is_write = 1'b1; req.addr = 32'h100; req.len = MLEN4;
    req.burst = AXI_BURST_INCR; req.size = MSIZE_8B; req.strobe = 8'hFF; req.data = pat_q[0];
    tick();
    req.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_lw_ready", 64'(resp.ready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(1'b0, 32'h100, 3, AXI_BURST_INCR, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) check_eq("rst_lw_mem", rbuf[i], pat_p[i]);

    // Reset after two committed beats
    req.valid = 1'b1; req.is_write = 1'b1; req.addr = 32'h100; req.len = MLEN4;
    req.burst = AXI_BURST_INCR; req.strobe = 8'hFF; req.data = pat_q[0];
    tick();
    req.valid = 1'b0;
    tick();
    tick();
    check_eq("rst_bt_b0", 64'(resp.ready), 64'd1);
    req.data = pat_q[1];
    tick();
    check_eq("rst_bt_b1", 64'(resp.ready), 64'd1);
    req.data = pat_q[2];
    rst_n = 1'b0;
    #1;
    check_eq("rst_bt_ready", 64'(resp.ready), 64'd0);
    check_eq("rst_bt_last", 64'(resp.last), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(1'b0, 32'h100, 3, AXI_BURST_INCR, 8'h00, 1'b0);
    check_eq("rst_bt_m0", rbuf[0], pat_q[0]);
    check_eq("rst_bt_m1", rbuf[1], pat_q[1]);
    check_eq("rst_bt_m2", rbuf[2], pat_p[2]);
    check_eq("rst_bt_m3", rbuf[3], pat_p[3]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
